// File: rtl/i2s_tx.sv
// I2S master transmitter: derives scki/bck/lrck from clk and serializes one 24-bit stereo frame per lrck period.
// Define I2S_TX_LJ_EN for left-justified output (no delay slot, lrck high on the left half).
module i2s_tx #(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] left,
  input  logic [WIDTH-1:0] right,
  input  logic             sample_valid,
  output logic             sample_ready,
  input  logic             clear_underrun,
  output logic             scki,
  output logic             bck,
  output logic             lrck,
  output logic             sdout,
  output logic             frame_start,
  output logic             underrun
);

  logic [7:0]       r_p;
  logic [WIDTH-1:0] r_bufL;
  logic [WIDTH-1:0] r_bufR;
  logic             r_bufFull;
  logic [WIDTH-1:0] r_actL;
  logic [WIDTH-1:0] r_actR;
  logic             r_sdout;
  logic             r_frameStart;
  logic             r_underrun;

  logic             w_boundary;
  logic             w_accept;
  logic             w_load;
  logic [5:0]       w_nextUpper;
  logic [4:0]       w_nextSlot;
  logic             w_nextHalf;
  logic [WIDTH-1:0] w_srcL;
  logic [WIDTH-1:0] w_srcR;
  logic [WIDTH-1:0] w_word;
  logic             w_bit;

  assign w_boundary   = (r_p == 8'd255);
  assign sample_ready = ~r_bufFull & ~reset;
  assign w_accept     = sample_valid & sample_ready;
  assign w_load       = w_boundary & r_bufFull;

  // sdout is only updated when p[1:0] == 3, so the slot it will carry is that of p+1.
  assign w_nextUpper = r_p[7:2] + 6'd1;
  assign w_nextSlot  = w_nextUpper[4:0];
  assign w_nextHalf  = w_nextUpper[5];
  assign w_srcL      = w_load ? r_bufL : r_actL;
  assign w_srcR      = w_load ? r_bufR : r_actR;
  assign w_word      = w_nextHalf ? w_srcR : w_srcL;

  always_comb begin
    w_bit = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
`ifdef I2S_TX_LJ_EN
      if (w_nextSlot == 5'(WIDTH - 1 - i)) w_bit = w_word[i];
`else
      if (w_nextSlot == 5'(WIDTH - i)) w_bit = w_word[i];
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_p          <= 8'd0;
      r_frameStart <= 1'b0;
      r_sdout      <= 1'b0;
    end else begin
      r_p          <= r_p + 8'd1;
      r_frameStart <= w_boundary;
      if (r_p[1:0] == 2'b11) r_sdout <= w_bit;
    end
  end

  // A frame accepted on the boundary edge lands in the buffer, so that boundary still counts as empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bufL    <= '0;
      r_bufR    <= '0;
      r_bufFull <= 1'b0;
      r_actL    <= '0;
      r_actR    <= '0;
    end else begin
      if (w_load) begin
        r_actL <= r_bufL;
        r_actR <= r_bufR;
      end
      if (w_accept) begin
        r_bufL <= left;
        r_bufR <= right;
      end
      r_bufFull <= w_accept | (r_bufFull & ~w_boundary);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_underrun <= 1'b0;
    end else if (w_boundary && !r_bufFull) begin
      r_underrun <= 1'b1;
    end else if (clear_underrun) begin
      r_underrun <= 1'b0;
    end
  end

  assign scki        = clk;
  assign bck         = r_p[1];
`ifdef I2S_TX_LJ_EN
  assign lrck        = ~r_p[7];
`else
  assign lrck        = r_p[7];
`endif
  assign sdout       = r_sdout;
  assign frame_start = r_frameStart;
  assign underrun    = r_underrun;

endmodule
